// File: rtl/bus_mem_pkg.sv
// Shared constants and types for the bus memory slave.
package bus_mem_pkg;

  localparam int unsigned LANES   = 4;
  localparam int unsigned DATA_W  = 8 * LANES;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned COUNT_W = 16;

  localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 32'hBFC00000;

  typedef enum logic {
    IDLE,
    WAIT
  } wait_state_e;

  // A write with no lanes enabled is treated as a full-word write.
  function automatic logic [LANES-1:0] eff_byteenable(input logic [LANES-1:0] be);
    return (be == '0) ? '1 : be;
  endfunction

endpackage

// File: rtl/bus_mem_wait_ctr.sv
// Wait-state generator: stalls each request for WAIT_CYCLES cycles before acceptance.
module bus_mem_wait_ctr
  import bus_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  output logic waitrequest_o,
  output logic accept_o
);

  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_CYCLES);

  wait_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stall;

  // Counter never exceeds LIMIT (it clears on acceptance), so inequality
  // is the same test as cnt < WAIT_CYCLES; in IDLE the count is zero.
  // Holding reset low removes the stall so a pending request is dropped.
  always_comb begin
    stall         = req_i && rst_ni &&
                    ((state_q == IDLE) ? (LIMIT != '0) : (cnt_q != LIMIT));
    waitrequest_o = stall;
    accept_o      = req_i && rst_ni && !stall;
    if (stall) begin
      state_d = WAIT;
      cnt_d   = cnt_q + CW'(1);
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Wait-state register: counts stalled cycles, clears on accept or withdrawal.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_mem_slave.sv
// Word-addressed memory slave with byte lanes, wait states, error pulse and access counter.
module bus_mem_slave
  import bus_mem_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned       WAIT_CYCLES = 0,
  parameter string             INIT_FILE   = ""
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  address,
  input  logic               write,
  input  logic               read,
  output logic               waitrequest,
  input  logic [DATA_W-1:0]  writedata,
  input  logic [LANES-1:0]   byteenable,
  output logic [DATA_W-1:0]  readdata,
  output logic               err,
  output logic [COUNT_W-1:0] access_count
);

  localparam int unsigned       IW   = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH_WORDS * LANES);

  logic [DATA_W-1:0]  mem_q [DEPTH_WORDS];

  logic               req;
  logic               accept;
  logic [ADDR_W-1:0]  offset;
  logic               in_range;
  logic [IW-1:0]      idx;
  logic [LANES-1:0]   be_eff;
  logic               both;
  logic               null_read;
  logic               wr_en;
  logic               rd_en;

  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [COUNT_W-1:0] count_q, count_d;

  bus_mem_wait_ctr #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk_i        (clk),
    .rst_ni       (reset),
    .req_i        (req),
    .waitrequest_o(waitrequest),
    .accept_o     (accept)
  );

  // Address decode and access classification.
  // The unsigned subtraction wraps addresses below BASE_ADDR to large
  // offsets, so one compare covers both range bounds.
  always_comb begin
    req       = read | write;
    offset    = address - BASE_ADDR;
    in_range  = offset < SPAN;
    idx       = offset[IW+1:2];
    be_eff    = eff_byteenable(byteenable);
    both      = read && write;
    null_read = read && !write && (address == '0) && !in_range;
    wr_en     = accept && write && !read && in_range;
    rd_en     = accept && read && !write;

    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = in_range ? mem_q[idx] : '0;
    end

    err_d = accept && (both || (!in_range && !null_read));

    count_d = count_q;
    if (accept && (count_q != '1)) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // Memory starts zeroed and is not touched by reset.
  initial begin
    for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
      mem_q[i] = '0;
    end
  end

  // Memory array: lane-masked writes on accepted in-range writes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (be_eff[l]) begin
          mem_q[idx][8*l +: 8] <= writedata[8*l +: 8];
        end
      end
    end
  end

  // Registered outputs: read data, error pulse, saturating access count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign readdata     = rdata_q;
  assign err          = err_q;
  assign access_count = count_q;

endmodule

// File: tb/tb_bus_mem_slave.sv
// Scoreboard bench for bus_mem_slave: three instances with 0, 3 and 5 wait states.
module tb_bus_mem_slave;

  typedef struct {
    int          k;
    logic [31:0] rd;
    logic        er;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        rd      [3];
  logic        wr      [3];
  logic        waitreq [3];
  logic [31:0] rdata   [3];
  logic        err     [3];
  logic [15:0] acnt    [3];

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] cnt_m   [3];
  logic [31:0] last_rd [3];
  bit          pend    [3];
  int          tests;
  int          fails;
  int          waits;

  bus_mem_slave #(.DEPTH_WORDS(32), .BASE_ADDR(32'hBFC00000), .WAIT_CYCLES(0), .INIT_FILE("")) u0 (
    .clk(clk), .reset(reset), .address(addr), .write(wr[0]), .read(rd[0]),
    .waitrequest(waitreq[0]), .writedata(wdata), .byteenable(be),
    .readdata(rdata[0]), .err(err[0]), .access_count(acnt[0]));

  bus_mem_slave #(.DEPTH_WORDS(32), .BASE_ADDR(32'hBFC00000), .WAIT_CYCLES(3), .INIT_FILE("")) u3 (
    .clk(clk), .reset(reset), .address(addr), .write(wr[1]), .read(rd[1]),
    .waitrequest(waitreq[1]), .writedata(wdata), .byteenable(be),
    .readdata(rdata[1]), .err(err[1]), .access_count(acnt[1]));

  bus_mem_slave #(.DEPTH_WORDS(32), .BASE_ADDR(32'hBFC00000), .WAIT_CYCLES(5), .INIT_FILE("")) u5 (
    .clk(clk), .reset(reset), .address(addr), .write(wr[2]), .read(rd[2]),
    .waitrequest(waitreq[2]), .writedata(wdata), .byteenable(be),
    .readdata(rdata[2]), .err(err[2]), .access_count(acnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one access on instance k, queue its expected response, wait for acceptance.
  task automatic access(input int k, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input logic [31:0] exp_rd, input bit exp_err, output int nw);
    exp_t e;
    bit   done;
    addr  = a;
    wdata = d;
    be    = b;
    rd[k] = r;
    wr[k] = w;
    if (cnt_m[k] != 16'hFFFF) cnt_m[k] = cnt_m[k] + 16'd1;
    if (r && !w) last_rd[k] = exp_rd;
    e.k   = k;
    e.rd  = last_rd[k];
    e.er  = exp_err;
    e.cnt = cnt_m[k];
    sb.push_back(e);
    nw   = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!waitreq[k]) done = 1;
      else nw++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout dut%0d: got no acceptance, required one within 40 cycles", k);
    end
    @(posedge clk);
    #1;
    rd[k] = 1'b0;
    wr[k] = 1'b0;
  endtask

  // Monitor: one cycle after each acceptance, compare outputs with the queued expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (pend[k]) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow dut%0d: got empty queue, required an entry", k);
        end else begin
          mon_e = sb.pop_front();
          chk($sformatf("dut%0d_id", k), 32'(k), 32'(mon_e.k));
          chk($sformatf("dut%0d_readdata", k), rdata[k], mon_e.rd);
          chk($sformatf("dut%0d_err", k), {31'd0, err[k]}, {31'd0, mon_e.er});
          chk($sformatf("dut%0d_count", k), {16'd0, acnt[k]}, {16'd0, mon_e.cnt});
        end
      end
      pend[k] = reset && (rd[k] || wr[k]) && !waitreq[k];
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    addr  = '0;
    wdata = '0;
    be    = '0;
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; pend[k] = 0; cnt_m[k] = '0; last_rd[k] = '0;
    end

    // Reset state
    idle(3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_readdata%0d", k), rdata[k], 32'h0);
      chk($sformatf("rst_err%0d", k), {31'd0, err[k]}, 32'h0);
      chk($sformatf("rst_count%0d", k), {16'd0, acnt[k]}, 32'h0);
      chk($sformatf("rst_waitreq%0d", k), {31'd0, waitreq[k]}, 32'h0);
    end
    reset = 1'b1;
    idle(1);

    // Zero wait states: word 11 read back the next cycle
    access(0, 0, 1, 32'hBFC0002C, 32'h00000001, 4'hF, 32'h0, 0, waits);
    access(0, 1, 0, 32'hBFC0002C, 32'h0, 4'hF, 32'h00000001, 0, waits);
    chk("w0_waits", 32'(waits), 32'd0);
    access(0, 1, 0, 32'hBFC0002F, 32'h0, 4'hF, 32'h00000001, 0, waits);

    // Three wait states and a single-lane write
    access(1, 0, 1, 32'hBFC00008, 32'h11223344, 4'hF, 32'h0, 0, waits);
    chk("w3_write_waits", 32'(waits), 32'd3);
    access(1, 0, 1, 32'hBFC00008, 32'hAABBCCDD, 4'b0010, 32'h0, 0, waits);
    access(1, 1, 0, 32'hBFC00008, 32'h0, 4'hF, 32'h1122CC44, 0, waits);
    chk("w3_read_waits", 32'(waits), 32'd3);
    chk("w3_count", {16'd0, acnt[1]}, 32'd3);

    // Out-of-range write is discarded (its wrapped index would hit word 0)
    access(0, 0, 1, 32'hBFC00000, 32'hA0A0A0A0, 4'hF, 32'h0, 0, waits);
    access(0, 0, 1, 32'hBFC00080, 32'hFFFFFFFF, 4'hF, 32'h0, 1, waits);
    idle(1);
    chk("oor_err_pulse_end", {31'd0, err[0]}, 32'h0);
    access(0, 1, 0, 32'hBFC00000, 32'h0, 4'hF, 32'hA0A0A0A0, 0, waits);
    access(0, 1, 0, 32'h00000000, 32'h0, 4'hF, 32'h0, 0, waits);
    access(0, 1, 0, 32'hBFC00084, 32'h0, 4'hF, 32'h0, 1, waits);
    access(0, 1, 0, 32'hBFBFFFFC, 32'h0, 4'hF, 32'h0, 1, waits);

    // Read and write together: error, no memory change
    access(0, 0, 1, 32'hBFC00014, 32'h55555555, 4'hF, 32'h0, 0, waits);
    access(0, 1, 1, 32'hBFC00014, 32'h00000000, 4'hF, 32'h0, 1, waits);
    access(0, 1, 0, 32'hBFC00014, 32'h0, 4'hF, 32'h55555555, 0, waits);

    // Empty byteenable writes all lanes
    access(0, 0, 1, 32'hBFC00018, 32'hCAFEF00D, 4'b0000, 32'h0, 0, waits);
    access(0, 1, 0, 32'hBFC00018, 32'h0, 4'hF, 32'hCAFEF00D, 0, waits);

    // Read in the cycle right after a write
    access(0, 0, 1, 32'hBFC0001C, 32'h12345678, 4'hF, 32'h0, 0, waits);
    access(0, 1, 0, 32'hBFC0001C, 32'h0, 4'hF, 32'h12345678, 0, waits);

    // Reset during a write's wait phase: write dropped, wait count restarts
    access(2, 0, 1, 32'hBFC00010, 32'h44444444, 4'hF, 32'h0, 0, waits);
    chk("w5_write_waits", 32'(waits), 32'd5);
    addr  = 32'hBFC00010;
    wdata = 32'hDEADBEEF;
    be    = 4'hF;
    wr[2] = 1'b1;
    @(negedge clk);
    chk("abort_waitreq_hi", {31'd0, waitreq[2]}, 32'h1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_waitreq_lo", {31'd0, waitreq[2]}, 32'h0);
    chk("abort_count", {16'd0, acnt[2]}, 32'h0);
    chk("abort_readdata", rdata[2], 32'h0);
    wr[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cnt_m[k] = '0; last_rd[k] = '0;
    end
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    access(2, 1, 0, 32'hBFC00010, 32'h0, 4'hF, 32'h44444444, 0, waits);
    chk("restart_waits", 32'(waits), 32'd5);

    // Saturating counter: continuous back-to-back reads of word 11
    addr  = 32'hBFC0002C;
    rd[0] = 1'b1;
    last_rd[0] = 32'h00000001;
    for (int i = 0; i < 65540; i++) begin
      if (cnt_m[0] != 16'hFFFF) cnt_m[0] = cnt_m[0] + 16'd1;
      mon_e.k   = 0;
      mon_e.rd  = 32'h00000001;
      mon_e.er  = 1'b0;
      mon_e.cnt = cnt_m[0];
      sb.push_back(mon_e);
      @(posedge clk);
      #1;
    end
    rd[0] = 1'b0;
    idle(1);
    chk("sat_count", {16'd0, acnt[0]}, 32'h0000FFFF);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
